// File: rtl/qea_seq_pkg.sv
// Shared types and helpers for the QEA run sequencer.
//   seq_state_t : sequencer FSM states
//   rows_for()  : number of state RAM rows for a given qubit count
package qea_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CTX,
        INIT,
        START,
        RUN,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } seq_state_t;

    // Each row holds 2**pe_num_width amplitudes, so small registers still need one row.
    function automatic int unsigned rows_for(input int unsigned qbit_num,
                                             input int unsigned pe_num_width);
        if (qbit_num <= pe_num_width) begin
            return 1;
        end
        return 32'd1 << (qbit_num - pe_num_width);
    endfunction

endpackage

// File: rtl/qea_run_sequencer_if.sv
// Valid/ready stream bundle used for the context input and the state readout.
//   valid : producer has a word
//   ready : consumer takes the word this cycle
//   data  : DATA_W-bit payload
// master drives valid/data, slave drives ready.
interface qea_run_sequencer_if #(
    parameter int DATA_W = 64
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qea_seq_readout.sv
// State RAM readout datapath: issues the read, waits out the RAM latency,
// then holds the captured row on the output stream until it is accepted.
//   i_req        : sequencer is in RD_REQ
//   i_wait       : sequencer is in RD_WAIT
//   i_row        : row address to read
//   i_state_dout : state RAM read data
//   o_ena/o_addra: read request toward the state RAM
//   o_capture    : row captured this cycle (leave RD_WAIT)
//   o_accept     : output row accepted this cycle
//   m_state      : readout stream (master)
module qea_seq_readout #(
    parameter int ROW_WIDTH  = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic                  i_wait,
    input  logic [ADDR_WIDTH-1:0] i_row,
    input  logic [ROW_WIDTH-1:0]  i_state_dout,
    output logic                  o_ena,
    output logic [ADDR_WIDTH-1:0] o_addra,
    output logic                  o_capture,
    output logic                  o_accept,
    qea_run_sequencer_if.master   m_state
);

    localparam int LAT_W = 2;

    logic [LAT_W-1:0]     r_lat_cnt;
    logic                 r_valid;
    logic [ROW_WIDTH-1:0] r_data;

    assign o_ena         = i_req;
    assign o_addra       = i_row;
    assign o_capture     = i_wait && (r_lat_cnt == '0);
    assign o_accept      = r_valid && m_state.ready;
    assign m_state.valid = r_valid;
    assign m_state.data  = r_data;

    // Down-counter loaded at the request; the last RD_WAIT cycle sees terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            if (i_req) begin
                r_lat_cnt <= LAT_W'(RD_LAT - 1);
            end else if (i_wait && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            if (o_capture) begin
                r_data  <= i_state_dout;
                r_valid <= 1'b1;
            end else if (o_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qea_run_sequencer.sv
// Sequences one QEA execution: load context RAM, initialise state RAM to
// |0...0>, pulse start, wait for completion, stream every state row out.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   i_run/i_qbit_num/i_ins_num  : run request and its parameters (IDLE only)
//   s_ctx                       : context word stream in (slave)
//   o_ctx_*                     : context RAM write port
//   o_state_*, i_state_dout     : state RAM port
//   o_qea_qbit_num, o_qea_start : QEA control, i_qea_complete : QEA done level
//   m_state                     : state row stream out (master)
//   o_busy, o_done              : status
// Optional: define QEA_SEQ_CYCLE_CNT_EN to add o_exec_cycles (cycles spent in RUN).
//
// state    | meaning
// IDLE     | waiting for i_run
// LOAD_CTX | accepting context words into context RAM
// INIT     | writing |0...0> rows to state RAM
// START    | one-cycle QEA start pulse
// RUN      | waiting for i_qea_complete
// RD_REQ   | issuing state RAM read for current row
// RD_WAIT  | waiting RD_LAT cycles for read data
// RD_OUT   | presenting row until accepted
module qea_run_sequencer
    import qea_seq_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LAT                  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    i_ins_num,
    qea_run_sequencer_if.slave                    s_ctx,
    output logic                                  o_ctx_en,
    output logic                                  o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_ctx_data,
    output logic                                  o_state_ena,
    output logic                                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_state_dout,
    output logic [MAX_QBIT_WIDTH-1:0]             o_qea_qbit_num,
    output logic                                  o_qea_start,
    input  logic                                  i_qea_complete,
    qea_run_sequencer_if.master                   m_state,
    output logic                                  o_busy,
    output logic                                  o_done
`ifdef QEA_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]                           o_exec_cycles
`endif
);

    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
    // 1.0 in the real part of the most-significant lane.
    localparam logic [ROW_W-1:0] INIT_ROW0 = ROW_W'(1) << (ROW_W - DATA_WIDTH + NUM_FRAC_BIT);

    seq_state_t                         r_state, w_next;
    logic [MAX_QBIT_WIDTH-1:0]          r_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ins_num, r_beat, r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;
    logic [STATE_ADDR_WIDTH-1:0]        r_rows, r_row;
    logic                               r_ctx_en, r_skip, r_done;

    logic                               w_ctx_fire, w_last_beat, w_last_row;
    logic                               w_rd_ena, w_rd_capture, w_rd_accept;
    logic [STATE_ADDR_WIDTH-1:0]        w_rd_addr;

    assign w_ctx_fire     = s_ctx.valid && s_ctx.ready;
    assign w_last_beat    = (r_beat == r_ins_num - 1'b1);
    assign w_last_row     = (r_row == r_rows - 1'b1);
    assign o_ctx_en       = r_ctx_en;
    assign o_ctx_wea      = r_ctx_en;
    assign o_ctx_addr     = r_ctx_addr;
    assign o_ctx_data     = r_ctx_data;
    assign o_qea_qbit_num = r_qbit_num;
    assign o_done         = r_done;

    qea_seq_readout #(
        .ROW_WIDTH  (ROW_W),
        .ADDR_WIDTH (STATE_ADDR_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_readout (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (r_state == RD_REQ),
        .i_wait       (r_state == RD_WAIT),
        .i_row        (r_row),
        .i_state_dout (i_state_dout),
        .o_ena        (w_rd_ena),
        .o_addra      (w_rd_addr),
        .o_capture    (w_rd_capture),
        .o_accept     (w_rd_accept),
        .m_state      (m_state)
    );

    always_comb begin
        w_next        = r_state;
        s_ctx.ready   = 1'b0;
        o_qea_start   = 1'b0;
        o_busy        = (r_state != IDLE);
        o_state_ena   = 1'b0;
        o_state_wea   = 1'b0;
        o_state_addra = '0;
        o_state_dina  = '0;

        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_next = (i_ins_num == '0) ? INIT : LOAD_CTX;
                end
            end
            LOAD_CTX: begin
                s_ctx.ready = 1'b1;
                if (w_ctx_fire && w_last_beat) begin
                    w_next = INIT;
                end
            end
            INIT: begin
                o_state_ena   = 1'b1;
                o_state_wea   = 1'b1;
                o_state_addra = r_row;
                o_state_dina  = (r_row == '0) ? INIT_ROW0 : '0;
                if (w_last_row) begin
                    w_next = START;
                end
            end
            START: begin
                o_qea_start = 1'b1;
                w_next      = RUN;
            end
            RUN: begin
                // complete may still be high from the previous run for a cycle
                if (!r_skip && i_qea_complete) begin
                    w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                o_state_ena   = w_rd_ena;
                o_state_addra = w_rd_addr;
                w_next        = RD_WAIT;
            end
            RD_WAIT: begin
                if (w_rd_capture) begin
                    w_next = RD_OUT;
                end
            end
            RD_OUT: begin
                if (w_rd_accept) begin
                    w_next = w_last_row ? IDLE : RD_REQ;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_qbit_num <= '0;
            r_ins_num  <= '0;
            r_rows     <= '0;
            r_beat     <= '0;
            r_row      <= '0;
            r_ctx_en   <= 1'b0;
            r_ctx_addr <= '0;
            r_ctx_data <= '0;
            r_skip     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ctx_en <= w_ctx_fire;
            r_skip   <= (r_state == START);
            r_done   <= (r_state == RD_OUT) && w_rd_accept && w_last_row;

            if (w_ctx_fire) begin
                r_ctx_addr <= r_beat;
                r_ctx_data <= s_ctx.data;
                r_beat     <= r_beat + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (i_run) begin
                        r_qbit_num <= i_qbit_num;
                        r_ins_num  <= i_ins_num;
                        r_rows     <= STATE_ADDR_WIDTH'(rows_for(32'(i_qbit_num), PE_NUM_WIDTH));
                        r_beat     <= '0;
                        r_row      <= '0;
                    end
                end
                INIT:    r_row <= w_last_row ? '0 : r_row + 1'b1;
                RD_OUT: begin
                    if (w_rd_accept && !w_last_row) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef QEA_SEQ_CYCLE_CNT_EN
    logic [31:0] r_exec_cycles;

    assign o_exec_cycles = r_exec_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cycles <= '0;
        end else if (r_state == START) begin
            r_exec_cycles <= '0;
        end else if ((r_state == RUN) && (r_exec_cycles != '1)) begin
            r_exec_cycles <= r_exec_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qea_run_sequencer.sv
module tb_qea_run_sequencer;

    localparam int ROW_W        = 256;
    localparam int CTX_W        = 64;
    localparam int COMPLETE_DLY = 50;
    localparam logic [ROW_W-1:0] ROW0 = {64'h40000000_00000000, 192'h0};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_run = 1'b0;
    logic [5:0]        i_qbit_num = '0;
    logic [15:0]       i_ins_num = '0;
    logic              o_ctx_en, o_ctx_wea;
    logic [15:0]       o_ctx_addr;
    logic [CTX_W-1:0]  o_ctx_data;
    logic              o_state_ena, o_state_wea;
    logic [15:0]       o_state_addra;
    logic [ROW_W-1:0]  o_state_dina;
    logic [ROW_W-1:0]  ram_dout = '0;
    logic [5:0]        o_qea_qbit_num;
    logic              o_qea_start;
    logic              qea_complete = 1'b0;
    logic              o_busy, o_done;
`ifdef QEA_SEQ_CYCLE_CNT_EN
    logic [31:0]       o_exec_cycles;
`endif

    qea_run_sequencer_if #(.DATA_W(CTX_W)) ctx_if ();
    qea_run_sequencer_if #(.DATA_W(ROW_W)) st_if ();

    qea_run_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_run          (i_run),
        .i_qbit_num     (i_qbit_num),
        .i_ins_num      (i_ins_num),
        .s_ctx          (ctx_if),
        .o_ctx_en       (o_ctx_en),
        .o_ctx_wea      (o_ctx_wea),
        .o_ctx_addr     (o_ctx_addr),
        .o_ctx_data     (o_ctx_data),
        .o_state_ena    (o_state_ena),
        .o_state_wea    (o_state_wea),
        .o_state_addra  (o_state_addra),
        .o_state_dina   (o_state_dina),
        .i_state_dout   (ram_dout),
        .o_qea_qbit_num (o_qea_qbit_num),
        .o_qea_start    (o_qea_start),
        .i_qea_complete (qea_complete),
        .m_state        (st_if),
        .o_busy         (o_busy),
        .o_done         (o_done)
`ifdef QEA_SEQ_CYCLE_CNT_EN
        ,
        .o_exec_cycles  (o_exec_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ctx_cnt = 0, init_cnt = 0, rd_cnt = 0, done_cnt = 0, start_cnt = 0;
    int rd_addr_exp = 0;
    int rd_stall = 0;
    logic [15:0]      ctx_addr_q[$];
    logic [CTX_W-1:0] ctx_data_q[$];
    logic [15:0]      init_addr_q[$];
    logic [ROW_W-1:0] init_data_q[$];
    logic [ROW_W-1:0] rd_q[$];
    logic             hold_pending = 1'b0;
    logic [ROW_W-1:0] hold_data = '0;

    task automatic check_val(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [ROW_W-1:0] rd_row(input logic [15:0] a);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {16'hA000 + 16'(k), a};
        return r;
    endfunction

    // State RAM model: read data appears one cycle after the request.
    always @(posedge clk) begin
        if (o_state_ena && !o_state_wea) ram_dout <= rd_row(o_state_addra);
    end

    // QEA model: completion level rises COMPLETE_DLY cycles after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (o_qea_start) begin
                qea_complete = 1'b0;
                repeat (COMPLETE_DLY) @(posedge clk);
                #1 qea_complete = 1'b1;
            end
        end
    end

    // Readout consumer: optionally holds ready low rd_stall cycles per row.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        st_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_stall == 0) begin
                st_if.ready = 1'b1;
            end else if (st_if.valid) begin
                if (stall_cnt >= rd_stall) begin
                    st_if.ready = 1'b1;
                    stall_cnt = 0;
                end else begin
                    st_if.ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                st_if.ready = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Output monitor: pops scoreboard entries as the DUT produces them.
    always @(negedge clk) begin
        if (o_ctx_en) begin
            ctx_cnt++;
            check_val("ctx_wea", 256'(o_ctx_wea), 256'(1));
            if (ctx_addr_q.size() == 0) begin
                check_val("ctx_extra", 256'(1), 256'(0));
            end else begin
                check_val("ctx_addr", 256'(o_ctx_addr), 256'(ctx_addr_q.pop_front()));
                check_val("ctx_data", 256'(o_ctx_data), 256'(ctx_data_q.pop_front()));
            end
        end
        if (o_state_ena && o_state_wea) begin
            init_cnt++;
            if (init_addr_q.size() == 0) begin
                check_val("init_extra", 256'(1), 256'(0));
            end else begin
                check_val("init_addr", 256'(o_state_addra), 256'(init_addr_q.pop_front()));
                check_val("init_data", o_state_dina, init_data_q.pop_front());
            end
        end
        if (o_state_ena && !o_state_wea) begin
            check_val("rd_addr", 256'(o_state_addra), 256'(rd_addr_exp));
            rd_addr_exp++;
        end
        if (st_if.valid && hold_pending) check_val("rd_stable", st_if.data, hold_data);
        if (st_if.valid && st_if.ready) begin
            rd_cnt++;
            if (rd_q.size() == 0) check_val("rd_extra", 256'(1), 256'(0));
            else check_val("rd_data", st_if.data, rd_q.pop_front());
        end
        hold_pending = st_if.valid && !st_if.ready;
        hold_data    = st_if.data;
        if (o_done) done_cnt++;
        if (o_qea_start) start_cnt++;
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},  256'(o_busy), 256'(0));
        check_val({tag, "_ctx"},   256'({o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data}), 256'(0));
        check_val({tag, "_state"}, 256'({o_state_ena, o_state_wea, o_state_addra}), 256'(0));
        check_val({tag, "_dina"},  o_state_dina, 256'(0));
        check_val({tag, "_qea"},   256'({o_qea_qbit_num, o_qea_start, o_done}), 256'(0));
        check_val({tag, "_strm"},  256'({st_if.valid, ctx_if.ready}), 256'(0));
        check_val({tag, "_rdata"}, st_if.data, 256'(0));
    endtask

    task automatic run_seq(input logic [5:0] qn, input logic [15:0] in, input bit toggle,
                           input int stall, input bit inject, input bit abort);
        int rows, cyc, idx, ctx0, init0, rd0, done0, start0;
        bit injected;
        logic [CTX_W-1:0] d;
        rows = (qn <= 2) ? 1 : (1 << (qn - 2));
        ctx0 = ctx_cnt; init0 = init_cnt; rd0 = rd_cnt; done0 = done_cnt; start0 = start_cnt;
        rd_stall = stall;
        rd_addr_exp = 0;
        injected = 1'b0;
        for (int r = 0; r < rows; r++) begin
            init_addr_q.push_back(16'(r));
            init_data_q.push_back((r == 0) ? ROW0 : '0);
            rd_q.push_back(rd_row(16'(r)));
        end

        @(posedge clk); #1;
        i_run = 1'b1; i_qbit_num = qn; i_ins_num = in;
        @(posedge clk); #1;
        i_run = 1'b0;
        check_val("busy_after_run", 256'(o_busy), 256'(1));

        idx = 0; cyc = 0;
        while (idx < int'(in) && cyc < 4000) begin
            ctx_if.valid = toggle ? (cyc % 2 == 0) : 1'b1;
            d = {16'hC7A0, 16'(idx), 32'($urandom)};
            ctx_if.data = d;
            i_run = 1'b0;
            if (inject && !injected && idx == 100) begin
                i_run = 1'b1; i_qbit_num = 6'd3; i_ins_num = 16'd5;
                injected = 1'b1;
            end
            @(negedge clk);
            if (ctx_if.valid && ctx_if.ready) begin
                ctx_addr_q.push_back(16'(idx));
                ctx_data_q.push_back(d);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ctx_if.valid = 1'b0;
        i_run = 1'b0;
        check_val("ctx_beats", 256'(idx), 256'(in));

        if (abort) begin
            cyc = 0;
            while (start_cnt == start0 && cyc < 2000) begin @(negedge clk); cyc++; end
            check_val("abort_start_seen", 256'(start_cnt - start0), 256'(1));
            repeat (10) @(negedge clk);
            check_val("abort_init_cnt", 256'(init_cnt - init0), 256'(rows));
            #2 rst_n = 1'b0;
            #1 check_all_zero("rst_run");
            @(posedge clk); #1 rst_n = 1'b1;
            rd_q.delete();
            return;
        end

        cyc = 0;
        while (done_cnt == done0 && cyc < 20000) begin @(negedge clk); cyc++; end
        check_val("done_seen", 256'(done_cnt != done0), 256'(1));
        repeat (4) @(negedge clk);
        check_val("ctx_writes",  256'(ctx_cnt - ctx0),   256'(in));
        check_val("init_writes", 256'(init_cnt - init0), 256'(rows));
        check_val("rd_rows",     256'(rd_cnt - rd0),     256'(rows));
        check_val("done_once",   256'(done_cnt - done0), 256'(1));
        check_val("start_once",  256'(start_cnt - start0), 256'(1));
        check_val("idle_after",  256'(o_busy), 256'(0));
        check_val("qbit_latched", 256'(o_qea_qbit_num), 256'(qn));
        check_val("queues_empty", 256'(ctx_addr_q.size() + init_addr_q.size() + rd_q.size()), 256'(0));
`ifdef QEA_SEQ_CYCLE_CNT_EN
        check_val("exec_cycles", 256'(o_exec_cycles), 256'(COMPLETE_DLY));
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ctx_if.valid = 1'b0;
        ctx_if.data  = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        run_seq(6'd6, 16'd219, 1'b0, 0, 1'b0, 1'b0);   // full rate
        run_seq(6'd6, 16'd219, 1'b1, 0, 1'b0, 1'b0);   // valid every other cycle
        run_seq(6'd6, 16'd219, 1'b0, 5, 1'b0, 1'b0);   // readout back-pressure
        run_seq(6'd2, 16'd0,   1'b0, 0, 1'b0, 1'b0);   // no context, one row
        run_seq(6'd3, 16'd5,   1'b1, 2, 1'b0, 1'b0);   // two rows
        run_seq(6'd4, 16'd3,   1'b0, 0, 1'b0, 1'b1);   // reset during RUN
        run_seq(6'd6, 16'd219, 1'b0, 0, 1'b1, 1'b0);   // restart, stray i_run while loading

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qea_run_sequencer.md
Name: qea_run_sequencer

Overview:
- Host-side controller that sequences one complete QEA execution.
- Streams gate-context words into the QEA context RAM, then initialises state RAM to the |0...0> basis state.
- Pulses start, waits for completion, then streams every state RAM row out over a valid/ready interface.
- Sits between the host/DMA fabric and the QEA instance. Replaces the hand-written load/start/readout sequence used in simulation benches.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM
- PE_NUM, 4, state lanes per RAM row
- DATA_WIDTH, 32, fixed-point component width
- STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude {re,im}
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, DATA_WIDTH*2, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, width of qubit count
- NUM_FRAC_BIT, 30, fraction bits; 1.0 = 1<<NUM_FRAC_BIT
- RD_LAT, 1, state RAM read latency in cycles (1..3)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_run  in  1  single-cycle run request, sampled only in IDLE
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_run
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, latched on accepted i_run
- s_ctx_valid / s_ctx_ready  in/out  1  context stream handshake
- s_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- o_ctx_en, o_ctx_wea  out  1  context RAM write strobe
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context RAM data
- o_state_ena, o_state_wea  out  1  state RAM port enable/write
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM address
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write row
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read row
- o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
- o_qea_start  out  1  one-cycle start pulse
- i_qea_complete  in  1  QEA completion level
- m_state_valid / m_state_ready  out/in  1  readout stream handshake
- m_state_data  out  PE_NUM*STATE_DATA_WIDTH  readout row
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse after the last readout row is accepted

Behaviour:
- Reset: async clear. All outputs are 0; o_qea_qbit_num=0; FSM goes to IDLE. Reset mid-operation abandons the run. The QEA's own reset is not touched.
- ROWS = 2**(qbit_num-PE_NUM_WIDTH). If qbit_num<=PE_NUM_WIDTH, ROWS=1. Row counter is STATE_ADDR_WIDTH bits.
- IDLE: i_run latches qbit_num/ins_num and moves to LOAD_CTX, or to INIT if ins_num==0. i_run is ignored while busy.
- LOAD_CTX:
  - s_ctx_ready=1.
  - Each valid&ready beat drives o_ctx_en=o_ctx_wea=1, addr=beat index (0..ins_num-1), data=s_ctx_data, registered (writes appear 1 cycle after handshake).
  - No strobe on idle cycles.
  - After beat ins_num-1, s_ctx_ready drops the next cycle and FSM goes to INIT.
- INIT:
  - Writes ROWS rows, one per cycle, addr 0..ROWS-1, ena=wea=1.
  - Row 0 has the most-significant lane real part = 1<<NUM_FRAC_BIT; all else is 0.
  - After the last row, go to START.
- START: o_qea_start=1 for exactly one cycle, then go to RUN.
- RUN:
  - Wait for i_qea_complete=1. It is not sampled in the cycle of or the cycle after start.
  - Then go to RD_REQ with row counter=0.
- RD_REQ: ena=1, wea=0, addr=row for one cycle, then RD_WAIT.
- RD_WAIT: count RD_LAT cycles, capture i_state_dout into m_state_data, assert m_state_valid, go to RD_OUT.
- RD_OUT:
  - Hold data/valid stable until m_state_ready.
  - On accept, deassert valid. If row==ROWS-1, pulse o_done and go to IDLE; otherwise increment row and go to RD_REQ.
- Throughput in readout is one row per RD_LAT+2 cycles minimum.
- Context address beyond 2**GATE_CONTEXT_ADDR_WIDTH is impossible: ins_num shares that width, max count = 2**W-1.

Optional Feature:
- Macro QEA_SEQ_CYCLE_CNT_EN.
- Defined:
  - Adds output o_exec_cycles (32 bits), reset 0.
  - Cleared on the o_qea_start cycle, incremented every cycle in RUN, frozen on leaving RUN, saturating at all-ones.
  - Holds its value until the next start.
- Undefined: port and counter are absent.

Decomposition:
- Package qea_seq_pkg: FSM state enum (IDLE, LOAD_CTX, INIT, START, RUN, RD_REQ, RD_WAIT, RD_OUT) and a function rows_for(qbit_num).
- Parameters stay module-level.
- One natural sub-module: qea_seq_readout (RD_REQ/RD_WAIT/RD_OUT datapath with skid-free output register).

Test Plan:
- qbit_num=6, ins_num=219 at full rate: 219 context writes, addr 0..218, data matches stream. 16 INIT writes with row0 = 64'h40000000_00000000 in the top lane. One start pulse.
- Context stream with valid toggling every other cycle: no write strobe on invalid cycles, addresses contiguous, exactly 219 writes.
- QEA model asserts complete 50 cycles after start; m_state_ready held low for 5 cycles per row: 16 rows emitted in addr order 0..15, data stable while stalled, o_done once.
- ins_num=0, qbit_num=2: LOAD_CTX skipped, ROWS=1, one INIT write, one readout row.
- rst_n pulled low during RUN: all outputs 0 immediately. A new i_run afterwards restarts with ctx addr 0.
- i_run pulsed during LOAD_CTX: ignored, latched values unchanged. With QEA_SEQ_CYCLE_CNT_EN, o_exec_cycles equals cycles spent in RUN.
